// File: rtl/mult_pkg.sv
// Shared state encoding and counter sizing for the two-requester multiplier arbiter.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    localparam int TIMEOUT_DEF = 63;
    localparam int CNT_W_DEF   = $clog2(TIMEOUT_DEF + 1);

    // Wide enough to hold 0..timeout; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not served last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       pick
);

    // grant selection
    always_comb begin
        valid = |req;
        pick  = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multi-cycle multiplier between two requesters with round-robin
// arbitration, a completion timeout and per-requester registered results.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int W       = 32
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           req0,
    input  logic           req1,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           done0,
    output logic           done1,
    output logic           err0,
    output logic           err1,
    output logic [2*W-1:0] res0,
    output logic [2*W-1:0] res1,
    output logic           busy,
    output logic           m_begin,
    output logic [W-1:0]   m_op1,
    output logic [W-1:0]   m_op2,
    input  logic [2*W-1:0] m_product,
    input  logic           m_end
);

    localparam int               CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [2*W-1:0]   RES_ZERO = {(2*W){1'b0}};
    localparam logic [W-1:0]     OP_ZERO  = {W{1'b0}};

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             last_r, last_s;
    logic             gnt_r, gnt_s;
    logic             begin_r, begin_s;
    logic [W-1:0]     op1_r, op1_s, op2_r, op2_s;
    logic [2*W-1:0]   res0_r, res0_s, res1_r, res1_s;
    logic             done0_r, done0_s, done1_r, done1_s;
    logic             err0_r, err0_s, err1_r, err1_s;
    logic             busy_r;
    logic             pick_valid_s, pick_s;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last_r),
        .valid (pick_valid_s),
        .pick  (pick_s)
    );

    // next-state and next-output logic; done/err default low so they pulse
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        gnt_s   = gnt_r;
        begin_s = begin_r;
        op1_s   = op1_r;
        op2_s   = op2_r;
        res0_s  = res0_r;
        res1_s  = res1_r;
        done0_s = 1'b0;
        done1_s = 1'b0;
        err0_s  = 1'b0;
        err1_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    gnt_s   = pick_s;
                    last_s  = pick_s;
                    op1_s   = pick_s ? a1 : a0;
                    op2_s   = pick_s ? b1 : b0;
                    begin_s = 1'b1;
                    cnt_s   = CNT_ZERO;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // m_end is checked first so a late completion beats the timeout
                if (m_end) begin
                    if (gnt_r) begin
                        res1_s  = m_product;
                        done1_s = 1'b1;
                    end else begin
                        res0_s  = m_product;
                        done0_s = 1'b1;
                    end
                    begin_s = 1'b0;
                    state_s = ST_REL;
                end else if (cnt_r == CNT_MAX) begin
                    if (gnt_r) begin
                        res1_s  = RES_ZERO;
                        done1_s = 1'b1;
                        err1_s  = 1'b1;
                    end else begin
                        res0_s  = RES_ZERO;
                        done0_s = 1'b1;
                        err0_s  = 1'b1;
                    end
                    begin_s = 1'b0;
                    state_s = ST_REL;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_REL: begin
                begin_s = 1'b0;
                if (!m_end) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REL;
                end
            end
            default: begin
                begin_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // datapath and output registers; last_r resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r   <= CNT_ZERO;
            last_r  <= 1'b1;
            gnt_r   <= 1'b0;
            begin_r <= 1'b0;
            op1_r   <= OP_ZERO;
            op2_r   <= OP_ZERO;
            res0_r  <= RES_ZERO;
            res1_r  <= RES_ZERO;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            err0_r  <= 1'b0;
            err1_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            gnt_r   <= gnt_s;
            begin_r <= begin_s;
            op1_r   <= op1_s;
            op2_r   <= op2_s;
            res0_r  <= res0_s;
            res1_r  <= res1_s;
            done0_r <= done0_s;
            done1_r <= done1_s;
            err0_r  <= err0_s;
            err1_r  <= err1_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign done0   = done0_r;
    assign done1   = done1_r;
    assign err0    = err0_r;
    assign err1    = err1_r;
    assign res0    = res0_r;
    assign res1    = res1_r;
    assign busy    = busy_r;
    assign m_begin = begin_r;
    assign m_op1   = op1_r;
    assign m_op2   = op2_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a 33-cycle signed multiplier model.
module tb_mult_arbiter;

    localparam int W       = 32;
    localparam int TIMEOUT = 63;

    logic           clk;
    logic           resetn;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           done0, done1, err0, err1, busy, m_begin, m_end;
    logic [2*W-1:0] res0, res1, m_product;
    logic [W-1:0]   m_op1, m_op2;
    logic           model_hang;
    int             mcnt;
    int             n_cmp = 0;
    int             n_bad = 0;

    mult_arbiter #(.TIMEOUT(TIMEOUT), .W(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .done0     (done0),
        .done1     (done1),
        .err0      (err0),
        .err1      (err1),
        .res0      (res0),
        .res1      (res1),
        .busy      (busy),
        .m_begin   (m_begin),
        .m_op1     (m_op1),
        .m_op2     (m_op2),
        .m_product (m_product),
        .m_end     (m_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier model: m_end 33 cycles after m_begin rises, held until m_begin drops
    always @(posedge clk) begin
        if (!resetn || !m_begin) begin
            mcnt  <= 0;
            m_end <= 1'b0;
        end else if (!model_hang && !m_end) begin
            if (mcnt == 32) begin
                m_end     <= 1'b1;
                m_product <= {{32{m_op1[31]}}, m_op1} * {{32{m_op2[31]}}, m_op2};
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        model_hang = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(1);
    endtask

    // cycles = samples after the call until doneN seen, or -1 when budget runs out
    task automatic wait_done(input bit which, input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            tick(1);
            cycles++;
            if ((which ? done1 : done0) === 1'b1) return;
        end
        cycles = -1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tick(2);
        n_cmp++;
        if ({busy, m_begin, done0, done1, err0, err1} !== 6'b000000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000", {busy, m_begin, done0, done1, err0, err1});
        end
        n_cmp++;
        if (res0 !== 64'd0 || res1 !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_res: got %h/%h want 0/0", res0, res1);
        end
        n_cmp++;
        if (m_op1 !== 32'd0 || m_op2 !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_ops: got %h/%h want 0/0", m_op1, m_op2);
        end
        resetn = 1'b1;
        tick(3);
        n_cmp++;
        if (busy !== 1'b0 || m_begin !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_req: busy=%b m_begin=%b want 0/0", busy, m_begin);
        end
    endtask

    task automatic test_single();
        int n0, n1, lat, errs;
        do_reset();
        a0 = 32'h00001111; b0 = 32'h00001111;
        a1 = 32'hDEAD0000; b1 = 32'h0000BEEF;
        req0 = 1'b1;
        tick(1);
        n_cmp++;
        if (m_begin !== 1'b1 || busy !== 1'b1 || m_op1 !== 32'h00001111 || m_op2 !== 32'h00001111) begin
            n_bad++;
            $display("FAIL single_grant: begin=%b busy=%b op=%h/%h want 1/1/00001111/00001111", m_begin, busy, m_op1, m_op2);
        end
        // request drops and operands change right after grant
        req0 = 1'b0;
        a0 = 32'h0000FFFF; b0 = 32'h00000003;
        n0 = 0; n1 = 0; lat = -1; errs = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (done0 === 1'b1) begin
                n0++;
                if (lat < 0) lat = i;
            end
            if (done1 === 1'b1) n1++;
            if (err0 === 1'b1 || err1 === 1'b1) errs++;
        end
        n_cmp++;
        if (n0 != 1 || n1 != 0 || errs != 0) begin
            n_bad++;
            $display("FAIL single_pulses: done0=%0d done1=%0d err=%0d want 1/0/0", n0, n1, errs);
        end
        n_cmp++;
        if (lat != 34) begin
            n_bad++;
            $display("FAIL single_latency: got %0d want 34", lat);
        end
        n_cmp++;
        if (res0 !== 64'h0000000001234321) begin
            n_bad++;
            $display("FAIL single_res0: got %h want 0000000001234321", res0);
        end
        n_cmp++;
        if (busy !== 1'b0 || m_op1 !== 32'h00001111) begin
            n_bad++;
            $display("FAIL single_after: busy=%b op1=%h want 0/00001111", busy, m_op1);
        end
    endtask

    task automatic test_both();
        int cyc;
        do_reset();
        a0 = 32'h00001111; b0 = 32'h00002222;
        a1 = 32'h00000002; b1 = 32'hFFFFFFFF;
        req0 = 1'b1;
        req1 = 1'b1;
        tick(1);
        n_cmp++;
        if (m_op1 !== 32'h00001111 || m_op2 !== 32'h00002222) begin
            n_bad++;
            $display("FAIL both_first_grant: op=%h/%h want 00001111/00002222", m_op1, m_op2);
        end
        req0 = 1'b0;
        wait_done(1'b0, 60, cyc);
        n_cmp++;
        if (cyc != 34 || res0 !== 64'h0000000002468642 || done1 !== 1'b0) begin
            n_bad++;
            $display("FAIL both_done0: cyc=%0d res0=%h done1=%b want 34/0000000002468642/0", cyc, res0, done1);
        end
        wait_done(1'b1, 60, cyc);
        req1 = 1'b0;
        n_cmp++;
        if (cyc != 37 || res1 !== 64'hFFFFFFFFFFFFFFFE) begin
            n_bad++;
            $display("FAIL both_done1: cyc=%0d res1=%h want 37/FFFFFFFFFFFFFFFE", cyc, res1);
        end
        n_cmp++;
        if (res0 !== 64'h0000000002468642) begin
            n_bad++;
            $display("FAIL both_res0_hold: got %h want 0000000002468642", res0);
        end
        tick(4);
    endtask

    task automatic test_back_to_back();
        bit exp;
        bit prev_begin;
        int ops, gap;
        do_reset();
        a0 = 32'd3; b0 = 32'd5; a1 = 32'd7; b1 = 32'd11;
        req0 = 1'b1;
        req1 = 1'b1;
        exp = 1'b0; prev_begin = 1'b0; ops = 0; gap = 0;
        for (int i = 0; i < 400 && ops < 4; i++) begin
            tick(1);
            if (m_begin === 1'b1 && prev_begin == 1'b0) begin
                n_cmp++;
                if (m_op1 !== (exp ? 32'd7 : 32'd3)) begin
                    n_bad++;
                    $display("FAIL b2b_grant%0d: op1=%h want %h", ops, m_op1, exp ? 32'd7 : 32'd3);
                end
                if (ops > 0) begin
                    n_cmp++;
                    if (gap < 1) begin
                        n_bad++;
                        $display("FAIL b2b_gap%0d: low cycles=%0d want >=1", ops, gap);
                    end
                end
            end
            if (m_begin === 1'b1) gap = 0; else gap++;
            if (done0 === 1'b1 || done1 === 1'b1) begin
                n_cmp++;
                if (done0 !== !exp || done1 !== exp ||
                    (exp ? res1 !== 64'd77 : res0 !== 64'd15)) begin
                    n_bad++;
                    $display("FAIL b2b_done%0d: done0=%b done1=%b res0=%0d res1=%0d want side %0d", ops, done0, done1, res0, res1, exp);
                end
                exp = ~exp;
                ops++;
            end
            prev_begin = m_begin;
        end
        n_cmp++;
        if (ops != 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d ops want 4", ops);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick(5);
    endtask

    task automatic test_timeout();
        int cyc;
        do_reset();
        a0 = 32'd3; b0 = 32'd5;
        req0 = 1'b1;
        tick(1);
        req0 = 1'b0;
        wait_done(1'b0, 60, cyc);
        n_cmp++;
        if (res0 !== 64'd15) begin
            n_bad++;
            $display("FAIL timeout_prime: res0=%h want 15", res0);
        end
        tick(4);
        model_hang = 1'b1;
        a0 = 32'd9; b0 = 32'd9;
        req0 = 1'b1;
        tick(1);
        req0 = 1'b0;
        wait_done(1'b0, 100, cyc);
        n_cmp++;
        if (cyc != TIMEOUT + 1 || err0 !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_pulse: cyc=%0d err0=%b want %0d/1", cyc, err0, TIMEOUT + 1);
        end
        n_cmp++;
        if (res0 !== 64'd0 || done1 !== 1'b0 || err1 !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_res: res0=%h done1=%b err1=%b want 0/0/0", res0, done1, err1);
        end
        tick(1);
        n_cmp++;
        if (done0 !== 1'b0 || err0 !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_after: done0=%b err0=%b busy=%b want 0/0/0", done0, err0, busy);
        end
        model_hang = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid_run();
        int cyc, n1;
        do_reset();
        a1 = 32'h00000002; b1 = 32'h80000000;
        req1 = 1'b1;
        tick(1);
        req1 = 1'b0;
        tick(10);
        n_cmp++;
        if (busy !== 1'b1 || m_begin !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_active: busy=%b m_begin=%b want 1/1", busy, m_begin);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({busy, m_begin, done0, done1, err0, err1} !== 6'b000000 ||
            res0 !== 64'd0 || res1 !== 64'd0 || m_op1 !== 32'd0 || m_op2 !== 32'd0) begin
            n_bad++;
            $display("FAIL midrun_async: flags=%b res=%h/%h op=%h/%h want all 0",
                     {busy, m_begin, done0, done1, err0, err1}, res0, res1, m_op1, m_op2);
        end
        tick(2);
        resetn = 1'b1;
        n1 = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (done1 === 1'b1 || err1 === 1'b1) n1++;
        end
        n_cmp++;
        if (n1 != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_abandon: pulses=%0d busy=%b want 0/0", n1, busy);
        end
        req1 = 1'b1;
        tick(1);
        req1 = 1'b0;
        wait_done(1'b1, 60, cyc);
        n_cmp++;
        if (cyc != 34 || res1 !== 64'hFFFFFFFF00000000) begin
            n_bad++;
            $display("FAIL midrun_reissue: cyc=%0d res1=%h want 34/FFFFFFFF00000000", cyc, res1);
        end
        tick(4);
    endtask

    initial begin
        resetn = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        model_hang = 1'b0;
        test_reset();
        test_single();
        test_both();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT, default 63, max cycles waited for m_end; W, default 32, operand width.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 req0, req1  in  1 each  level request from requester 0/1.
REQ-005 a0, b0, a1, b1  in  W each  operands of requester 0/1.
REQ-006 done0, done1  out  1 each  one-cycle completion pulse.
REQ-007 err0, err1  out  1 each  one-cycle timeout pulse, coincident with doneN.
REQ-008 res0, res1  out  2W each  registered product for requester 0/1.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 m_begin  out  1  start level to the shared multiplier.
REQ-011 m_op1, m_op2  out  W each  registered operands to the multiplier.
REQ-012 m_product  in  2W  multiplier result.
REQ-013 m_end  in  1  multiplier completion level.

Function
REQ-014 FSM states SHALL be IDLE, RUN, REL.
REQ-015 IDLE with at least one reqN high: grant one requester, latch aN/bN into m_op1/m_op2, set m_begin, clear cycle counter, enter RUN, all on the same edge.
REQ-016 Arbitration SHALL be round-robin: one request wins outright; both high -> grant the requester not served last; after reset requester 0 has priority.
REQ-017 RUN: m_begin held 1, m_op1/m_op2 stable, counter increments each cycle.
REQ-018 RUN with m_end=1: capture m_product into res of the granted requester, pulse its done for one cycle on the next edge, drop m_begin, enter REL.
REQ-019 RUN with counter = TIMEOUT and m_end=0: res of the granted requester set to 0, done and err pulsed together, m_begin dropped, enter REL.
REQ-020 m_end and timeout in the same cycle: m_end wins, no err.
REQ-021 REL: m_begin=0 for at least one cycle; return to IDLE in the first cycle m_end=0.
REQ-022 Operands SHALL be sampled only at grant; later aN/bN changes are ignored.
REQ-023 reqN dropping after grant SHALL NOT abort the operation; done still pulses.
REQ-024 reqN still high after doneN is a new request and competes in the next IDLE.
REQ-025 Minimum request-to-request spacing SHALL be IDLE + RUN (>= 1 cycle) + REL (>= 1 cycle).
REQ-026 m_product SHALL pass unchanged to resN; signedness is the multiplier's.
REQ-027 resN SHALL hold its value until that requester's next completion.

Reset
REQ-028 resetn=0 SHALL asynchronously force IDLE; busy, m_begin, done0/1, err0/1 = 0; res0/1, m_op1/m_op2 = 0; counter = 0; round-robin pointer favours requester 0.
REQ-029 Reset mid-RUN SHALL abandon the operation with no done/err pulse; m_begin low during reset.

Structure
REQ-030 State encoding, TIMEOUT default and counter width (clog2(TIMEOUT+1)) SHALL live in shared package mult_pkg.
REQ-031 A single combinational sub-module rr_pick2 (req pair + last-served pointer -> grant) is natural; the multiplier (multiply) is instantiated outside this block.

Verification
REQ-032 Bench SHALL use a multiplier model with 33-cycle latency, m_end held until m_begin drops.
REQ-033 req0, a0=0x00001111, b0=0x00001111 -> done0 once, res0=0x0000000001234321, done1 never pulses.
REQ-034 req0 and req1 high on the same cycle, a0=0x00001111, b0=0x00002222, a1=0x00000002, b1=0xFFFFFFFF (signed model) -> done0 first with res0=0x0000000002468642, then done1 with res1=0xFFFFFFFFFFFFFFFE.
REQ-035 req0 and req1 held continuously -> grants alternate 0,1,0,1; m_begin low for at least one cycle between operations.
REQ-036 Model never asserts m_end -> err0 and done0 exactly TIMEOUT+1 cycles after grant, res0=0, FSM returns to IDLE.
REQ-037 resetn pulsed low mid-RUN, a1=0x00000002, b1=0x80000000 -> no done1, all outputs zero; reissued request then gives res1=0xFFFFFFFF00000000.
